reg_writeback_queue: RTL and testbench
======================================

Name: reg_writeback_queue

Overview:
Write-side initiator for the MIPS register file. It accepts result writes (destination register plus data) from the ALU and memory stages over a valid/ready handshake, and buffers them in a small in-order queue. It retires one write per cycle onto the register file's write_reg/write_data/regWrite interface. A youngest-first bypass lookup lets the read side see values that are queued but not yet committed.

Parameters:
DEPTH, 4, number of queue entries (power of two, 2..16)
DATA_W, 32, register data width
ADDR_W, 5, register index width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer has a write request
in_ready  out  1  queue can accept; transfer occurs when in_valid && in_ready at a rising edge
in_reg  in  ADDR_W  destination register index
in_data  in  DATA_W  value to write
wb_stall  in  1  hold retirement this cycle (register file busy)
write_reg  out  ADDR_W  register index to the register file
write_data  out  DATA_W  data to the register file
regWrite  out  1  one-cycle write strobe to the register file
byp_reg1, byp_reg2  in  ADDR_W  lookup indices (mirror read_reg1/read_reg2)
byp_hit1, byp_hit2  out  1  a pending or in-flight write targets the index
byp_data1, byp_data2  out  DATA_W  youngest pending value for the index; 0 when there is no hit
q_count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (asynchronous, rst_n low):
  - queue empties, q_count=0
  - regWrite=0, write_reg=0, write_data=0
  - in_ready=0 while rst_n is low; in_ready=1 from the first clock after release
- in_ready = (q_count < DEPTH). It is registered-equivalent; there is no combinational path from in_valid to in_ready.
- Accept: an accepted request with in_reg==0 is dropped (register $0 is hardwired to zero). It is not enqueued and q_count does not change.
- Retire:
  - On each rising edge where q_count>0 and wb_stall=0, the head entry is popped into the output registers and regWrite=1 for exactly that cycle.
  - Otherwise regWrite=0; write_reg and write_data hold their last values.
- Latency: a request accepted at edge N, with an empty queue and no stall, appears with regWrite=1 after edge N+1. The request is never visible in the same cycle it is accepted.
- Throughput: one accept and one retire per cycle, sustained.
  - Simultaneous accept and retire: q_count is unchanged.
  - When full, a retire in the same cycle does not raise in_ready until the next cycle.
- Order: writes retire strictly in acceptance order. Repeated writes to the same register all retire; they are not merged.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from q_count only.
- Bypass (combinational), for each lookup port:
  - Search the queue from youngest to oldest, then the output stage while regWrite=1. The first match gives hit=1 and its data.
  - Index 0 never hits.
  - The input-side request of the current cycle is not searched.
- wb_stall held high: the queue fills to DEPTH, then in_ready=0. No write is lost or duplicated.
- rst_n asserted mid-operation: all pending writes are discarded and regWrite drops immediately (asynchronously).

Optional Feature:
Macro: REG_WB_STATS_EN
- Defined: adds 32-bit outputs wr_commit_cnt (increments on every regWrite pulse) and wr_zero_drop_cnt (increments on every accepted in_reg==0 request).
  - Both reset to 0 on rst_n.
  - Both wrap at 2^32 with no saturation.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - DATA_W=32, ADDR_W=5, ZERO_REG=5'd0
  - typedef wb_req_t {reg idx, data}
- One natural sub-module, wb_fifo: a parameterised DEPTH×wb_req_t storage with pointers and count. It exposes all entries plus the youngest-first valid mask for the bypass search in the parent.

Test Plan:
1. Reset then single write: in_reg=5, in_data=32'hDEADBEEF accepted at edge N -> regWrite=1, write_reg=5, write_data=DEADBEEF after edge N+1 only; q_count returns to 0.
2. Zero-register drop: accept in_reg=0, data=32'h1234 -> no regWrite pulse, q_count stays 0, byp_hit=0 for index 0.
3. Fill under stall: wb_stall=1, push regs 1..4 with data 10..13 -> in_ready=0 at q_count=4. Release the stall -> four pulses in order 1/10, 2/11, 3/12, 4/13, with no gaps.
4. Bypass priority: under stall, push reg7=32'hA, then reg7=32'hB -> byp_reg1=7 gives hit=1, data=32'hB. After the first retire it still gives B; after both retires and the output stage clears, hit=0.
5. Back-to-back streaming: 20 consecutive writes with in_valid held high and no stall -> one regWrite per cycle, q_count ≤1, pointers wrap with no loss.
6. Async reset mid-stream: assert rst_n low with 3 entries queued and regWrite=1 -> regWrite=0 immediately, q_count=0. After release, no stale writes retire.

Source files
------------

// File: rtl/reg_writeback_queue_pkg.sv
// Shared MIPS register-file definitions used by the writeback queue.
// Optional statistics counters are enabled with the REG_WB_STATS_EN macro.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// Producer-side write request handshake (valid/ready) into the writeback queue.
interface reg_writeback_queue_if #(
   parameter int ADDR_W = mips_pkg::ADDR_W,
   parameter int DATA_W = mips_pkg::DATA_W
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_reg;
   logic [DATA_W-1:0] in_data;

   modport master (output in_valid, in_reg, in_data, input in_ready);
   modport slave  (input in_valid, in_reg, in_data, output in_ready);
endinterface

// File: rtl/reg_writeback_queue_wb_fifo.sv
// In-order request storage with wrap-around pointers and occupancy count;
// also presents every entry reordered youngest-first for the bypass search.
module wb_fifo
   import mips_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = wb_req_t,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  T                 push_data,
   input  logic             pop,
   output T                 head,
   output logic [CW-1:0]    count,
   output T [DEPTH-1:0]     ent_yf,
   output logic [DEPTH-1:0] vld_yf
);

   T [DEPTH-1:0]  mem;
   logic [PW-1:0] wr_ptr, rd_ptr;

   // Storage carries no reset; validity is tracked solely by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head = mem[rd_ptr];

   // Slot 0 is the most recently written entry; only the first count slots are live.
   for (genvar i = 0; i < DEPTH; i++) begin : g_yf
      assign ent_yf[i] = mem[wr_ptr - PW'(i + 1)];
      assign vld_yf[i] = (CW'(i) < count);
   end

endmodule

// File: rtl/reg_writeback_queue.sv
// Buffered register-file write initiator: queues result writes, retires one per
// cycle, and offers youngest-first bypass lookups. REG_WB_STATS_EN adds counters.
module reg_writeback_queue
   import mips_pkg::*;
#(
   parameter int  DEPTH  = 4,
   parameter int  DATA_W = mips_pkg::DATA_W,
   parameter int  ADDR_W = mips_pkg::ADDR_W,
   localparam int CW     = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   reg_writeback_queue_if.slave in_if,
   input  logic                 wb_stall,
   output logic [ADDR_W-1:0]    write_reg,
   output logic [DATA_W-1:0]    write_data,
   output logic                 regWrite,
   input  logic [ADDR_W-1:0]    byp_reg1,
   input  logic [ADDR_W-1:0]    byp_reg2,
   output logic                 byp_hit1,
   output logic                 byp_hit2,
   output logic [DATA_W-1:0]    byp_data1,
   output logic [DATA_W-1:0]    byp_data2,
`ifdef REG_WB_STATS_EN
   output logic [31:0]          wr_commit_cnt,
   output logic [31:0]          wr_zero_drop_cnt,
`endif
   output logic [CW-1:0]        q_count
);

   localparam int NUM_LANES = 2;

   typedef struct packed {
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
   } req_t;

   logic              in_ready_q;
   logic              accept, push, pop, zero_drop;
   logic [CW-1:0]     cnt_nxt;
   req_t              push_req, head;
   req_t [DEPTH-1:0]  ent_yf;
   logic [DEPTH-1:0]  vld_yf;

   assign accept    = in_if.in_valid && in_ready_q;
   assign zero_drop = accept && (in_if.in_reg == ADDR_W'(ZERO_REG));
   assign push      = accept && !zero_drop;
   assign pop       = (q_count != '0) && !wb_stall;
   assign cnt_nxt   = q_count + CW'(push) - CW'(pop);
   assign push_req  = '{idx: in_if.in_reg, data: in_if.in_data};

   assign in_if.in_ready = in_ready_q;

   wb_fifo #(.DEPTH(DEPTH), .T(req_t)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_req),
      .pop       (pop),
      .head      (head),
      .count     (q_count),
      .ent_yf    (ent_yf),
      .vld_yf    (vld_yf)
   );

   // in_ready follows next-cycle occupancy, so a retire while full frees a slot one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_q <= 1'b0;
         regWrite   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
      end else begin
         in_ready_q <= (cnt_nxt < CW'(DEPTH));
         regWrite   <= pop;
         if (pop) begin
            write_reg  <= head.idx;
            write_data <= head.data;
         end
      end
   end

   logic [NUM_LANES-1:0][ADDR_W-1:0] byp_reg;
   logic [NUM_LANES-1:0]             byp_hit;
   logic [NUM_LANES-1:0][DATA_W-1:0] byp_data;

   assign byp_reg = {byp_reg2, byp_reg1};

   // Later assignments win: output stage first, then queue oldest-to-youngest.
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_byp
      logic              hit;
      logic [DATA_W-1:0] dat;

      always_comb begin
         hit = 1'b0;
         dat = '0;
         if (byp_reg[l] != ADDR_W'(ZERO_REG)) begin
            if (regWrite && (write_reg == byp_reg[l])) begin
               hit = 1'b1;
               dat = write_data;
            end
            for (int i = DEPTH - 1; i >= 0; i--) begin
               if (vld_yf[i] && (ent_yf[i].idx == byp_reg[l])) begin
                  hit = 1'b1;
                  dat = ent_yf[i].data;
               end
            end
         end
      end

      assign byp_hit[l]  = hit;
      assign byp_data[l] = dat;
   end

   assign byp_hit1  = byp_hit[0];
   assign byp_hit2  = byp_hit[1];
   assign byp_data1 = byp_data[0];
   assign byp_data2 = byp_data[1];

`ifdef REG_WB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_commit_cnt    <= '0;
         wr_zero_drop_cnt <= '0;
      end else begin
         if (pop)       wr_commit_cnt    <= wr_commit_cnt + 32'd1;
         if (zero_drop) wr_zero_drop_cnt <= wr_zero_drop_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench: vector table for handshake/bypass plus scoreboarded retire order.
module tb_reg_writeback_queue;

   logic        clk, rst_n, wb_stall;
   logic [4:0]  write_reg, byp_reg1, byp_reg2;
   logic [31:0] write_data, byp_data1, byp_data2;
   logic        regWrite, byp_hit1, byp_hit2;
   logic [2:0]  q_count;
`ifdef REG_WB_STATS_EN
   logic [31:0] wr_commit_cnt, wr_zero_drop_cnt;
`endif

   reg_writeback_queue_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   reg_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_if      (bus),
      .wb_stall   (wb_stall),
      .write_reg  (write_reg),
      .write_data (write_data),
      .regWrite   (regWrite),
      .byp_reg1   (byp_reg1),
      .byp_reg2   (byp_reg2),
      .byp_hit1   (byp_hit1),
      .byp_hit2   (byp_hit2),
      .byp_data1  (byp_data1),
      .byp_data2  (byp_data2),
`ifdef REG_WB_STATS_EN
      .wr_commit_cnt    (wr_commit_cnt),
      .wr_zero_drop_cnt (wr_zero_drop_cnt),
`endif
      .q_count    (q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [4:0]  r;
      logic [31:0] d;
      logic        st;
      logic [4:0]  b1, b2;
      logic [2:0]  cnt;
      logic        rdy, rw, h1;
      logic [31:0] d1;
      logic        h2;
      logic [31:0] d2;
   } vec_t;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pulse_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic v, logic [4:0] r, logic [31:0] d, logic st,
                               logic [4:0] b1, logic [4:0] b2, logic [2:0] cnt,
                               logic rdy, logic rw, logic h1, logic [31:0] d1,
                               logic h2, logic [31:0] d2);
      vec_t t;
      t.v = v; t.r = r; t.d = d; t.st = st; t.b1 = b1; t.b2 = b2;
      t.cnt = cnt; t.rdy = rdy; t.rw = rw; t.h1 = h1; t.d1 = d1; t.h2 = h2; t.d2 = d2;
      return t;
   endfunction

   task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d, input logic st);
      bus.in_valid = v;
      bus.in_reg   = r;
      bus.in_data  = d;
      wb_stall     = st;
   endtask

   // Retire monitor: every regWrite pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && regWrite) begin
         pulse_cnt++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%0d/%0h expected=none", write_reg, write_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_reg", 64'(write_reg), 64'(e.r));
            chk("sb_data", 64'(write_data), 64'(e.d));
         end
      end
   end

   initial begin
      int p0;
      rst_n = 1'b1;
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      byp_reg1 = '0;
      byp_reg2 = '0;

      //   v  r   d             st b1 b2  cnt rdy rw h1 d1            h2 d2
      tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 5, 0, 0, 1, 0, 0, 0,            0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 5, 0, 1, 1, 0, 1, 32'hDEADBEEF, 0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 5, 0, 0, 1, 1, 1, 32'hDEADBEEF, 0, 0));
      tbl.push_back(mk(1, 0, 32'h1234,     0, 0, 5, 0, 1, 0, 0, 0,            0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 0,            0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 0, 0, 0,            0, 0));
      tbl.push_back(mk(1, 1, 10,           1, 1, 2, 0, 1, 0, 0, 0,            0, 0));
      tbl.push_back(mk(1, 2, 11,           1, 1, 2, 1, 1, 0, 1, 10,           0, 0));
      tbl.push_back(mk(1, 3, 12,           1, 1, 2, 2, 1, 0, 1, 10,           1, 11));
      tbl.push_back(mk(1, 4, 13,           1, 3, 4, 3, 1, 0, 1, 12,           0, 0));
      tbl.push_back(mk(1, 9, 99,           1, 4, 9, 4, 0, 0, 1, 13,           0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 9, 1, 4, 0, 0, 0, 0,            1, 10));
      tbl.push_back(mk(0, 0, 0,            0, 1, 2, 3, 1, 1, 1, 10,           1, 11));
      tbl.push_back(mk(0, 0, 0,            0, 1, 2, 2, 1, 1, 0, 0,            1, 11));
      tbl.push_back(mk(0, 0, 0,            0, 3, 4, 1, 1, 1, 1, 12,           1, 13));
      tbl.push_back(mk(0, 0, 0,            0, 4, 3, 0, 1, 1, 1, 13,           0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 4, 0, 0, 1, 0, 0, 0,            0, 0));
      tbl.push_back(mk(1, 7, 32'hA,        1, 7, 0, 0, 1, 0, 0, 0,            0, 0));
      tbl.push_back(mk(1, 7, 32'hB,        1, 7, 0, 1, 1, 0, 1, 32'hA,        0, 0));
      tbl.push_back(mk(0, 0, 0,            1, 7, 0, 2, 1, 0, 1, 32'hB,        0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 7, 0, 2, 1, 0, 1, 32'hB,        0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 7, 0, 1, 1, 1, 1, 32'hB,        0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 7, 0, 0, 1, 1, 1, 32'hB,        0, 0));
      tbl.push_back(mk(0, 0, 0,            0, 7, 0, 0, 1, 0, 0, 0,            0, 0));

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_q_count", 64'(q_count), 64'd0);
      chk("rst_regWrite", 64'(regWrite), 64'd0);
      chk("rst_write_reg", 64'(write_reg), 64'd0);
      chk("rst_write_data", 64'(write_data), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      rst_n = 1'b1;

      // Vector table: expectations describe state before the row's inputs are clocked.
      for (int k = 0; k < tbl.size(); k++) begin
         @(posedge clk); #1;
         drive(tbl[k].v, tbl[k].r, tbl[k].d, tbl[k].st);
         byp_reg1 = tbl[k].b1;
         byp_reg2 = tbl[k].b2;
         if (tbl[k].v && tbl[k].rdy && tbl[k].r != 5'd0) sb.push_back('{r: tbl[k].r, d: tbl[k].d});
         @(negedge clk);
         chk($sformatf("v%0d_q_count", k), 64'(q_count), 64'(tbl[k].cnt));
         chk($sformatf("v%0d_in_ready", k), 64'(bus.in_ready), 64'(tbl[k].rdy));
         chk($sformatf("v%0d_regWrite", k), 64'(regWrite), 64'(tbl[k].rw));
         chk($sformatf("v%0d_hit1", k), 64'(byp_hit1), 64'(tbl[k].h1));
         chk($sformatf("v%0d_data1", k), 64'(byp_data1), 64'(tbl[k].d1));
         chk($sformatf("v%0d_hit2", k), 64'(byp_hit2), 64'(tbl[k].h2));
         chk($sformatf("v%0d_data2", k), 64'(byp_data2), 64'(tbl[k].d2));
      end

      // Back-to-back streaming: 20 writes, one retire per cycle, pointers wrap.
      byp_reg1 = '0;
      byp_reg2 = '0;
      p0 = pulse_cnt;
      for (int i = 0; i < 20; i++) begin
         logic [4:0]  r;
         logic [31:0] d;
         @(posedge clk); #1;
         r = 5'((i % 31) + 1);
         d = $urandom;
         drive(1'b1, r, d, 1'b0);
         sb.push_back('{r: r, d: d});
         @(negedge clk);
         chk($sformatf("s%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
         chk($sformatf("s%0d_q_le1", i), 64'(q_count <= 3'd1), 64'd1);
         if (i >= 2) chk($sformatf("s%0d_regWrite", i), 64'(regWrite), 64'd1);
      end
      @(posedge clk); #1;
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("stream_pulses", 64'(pulse_cnt - p0), 64'd20);
      chk("stream_drained", 64'(sb.size()), 64'd0);

      // Async reset with three entries queued and a pulse in flight.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         drive(1'b1, 5'(20 + i), 32'(32'h100 + i), 1'b1);
         sb.push_back('{r: 5'(20 + i), d: 32'(32'h100 + i)});
      end
      @(posedge clk); #1;
      drive(1'b0, 5'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ar_pre_regWrite", 64'(regWrite), 64'd1);
      chk("ar_pre_q_count", 64'(q_count), 64'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_regWrite", 64'(regWrite), 64'd0);
      chk("ar_q_count", 64'(q_count), 64'd0);
      chk("ar_in_ready", 64'(bus.in_ready), 64'd0);
      sb.delete();
      p0 = pulse_cnt;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("ar_no_stale", 64'(pulse_cnt - p0), 64'd0);
      chk("ar_post_q_count", 64'(q_count), 64'd0);
      chk("ar_post_in_ready", 64'(bus.in_ready), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
